// File: rtl/gcd_engine.sv
// Binary (Stein) GCD engine with valid/ready handshakes, abort, coprime flag
// and a saturating per-job step counter.
module gcd_engine #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_coprime,
  output logic [CNT_W-1:0] out_steps
);

  localparam int N_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OP,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             coprime_q, coprime_d;
  logic [CNT_W-1:0] out_steps_q, out_steps_d;

  logic             a_zero, b_zero, ab_equal;
  logic [CNT_W-1:0] steps_inc;
  logic [WIDTH-1:0] result_base, result;

  assign a_zero    = (a_q == '0);
  assign b_zero    = (b_q == '0);
  assign ab_equal  = (a_q == b_q);
  assign steps_inc = (steps_q == '1) ? steps_q : steps_q + CNT_W'(1);

  // Both terminating rules share one barrel shift; a|b equals the nonzero operand.
  assign result_base = (a_zero || b_zero) ? (a_q | b_q) : a_q;
  assign result      = result_base << n_q;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    n_d         = n_q;
    steps_d     = steps_q;
    gcd_d       = gcd_q;
    coprime_d   = coprime_q;
    out_steps_d = out_steps_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          n_d     = '0;
          steps_d = '0;
          state_d = S_OP;
        end
      end

      S_OP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          steps_d = steps_inc;
          if (a_zero || b_zero || ab_equal) begin
            gcd_d       = result;
            coprime_d   = (result == WIDTH'(1));
            out_steps_d = steps_inc;
            state_d     = S_DONE;
          end else if (!a_q[0] && !b_q[0]) begin
            a_d = a_q >> 1;
            b_d = b_q >> 1;
            n_d = n_q + N_W'(1);
          end else if (!a_q[0]) begin
            a_d = a_q >> 1;
          end else if (!b_q[0]) begin
            b_d = b_q >> 1;
          end else if (a_q > b_q) begin
            a_d = a_q - b_q;
          end else begin
            b_d = b_q - a_q;
          end
        end
      end

      S_DONE: begin
        // Abort takes precedence over a simultaneous output handshake.
        if (abort || out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      n_q         <= '0;
      steps_q     <= '0;
      gcd_q       <= '0;
      coprime_q   <= 1'b0;
      out_steps_q <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      n_q         <= n_d;
      steps_q     <= steps_d;
      gcd_q       <= gcd_d;
      coprime_q   <= coprime_d;
      out_steps_q <= out_steps_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign out_gcd     = gcd_q;
  assign out_coprime = coprime_q;
  assign out_steps   = out_steps_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Directed scoreboard bench for gcd_engine: default, CNT_W=4 and WIDTH=8 instances.
module tb_gcd_engine;

  typedef struct {
    logic [31:0] gcd;
    logic        cop;
    logic [15:0] steps;
    int          k;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  in_valid_v;
  logic [31:0] in_a, in_b;
  logic        abort, out_ready;

  logic        ir0, ov0, oc0;
  logic [31:0] og0;
  logic [15:0] os0;
  logic        ir1, ov1, oc1;
  logic [31:0] og1;
  logic [3:0]  os1;
  logic        ir2, ov2, oc2;
  logic [7:0]  og2;
  logic [15:0] os2;

  int          sel;
  logic        obs_ready, obs_valid, obs_cop;
  logic [31:0] obs_gcd;
  logic [15:0] obs_steps;

  exp_t        sb[$];
  exp_t        last_e;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  gcd_engine #(.WIDTH(32), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(ir0),
    .in_a(in_a), .in_b(in_b), .abort(abort), .out_valid(ov0), .out_ready(out_ready),
    .out_gcd(og0), .out_coprime(oc0), .out_steps(os0)
  );

  gcd_engine #(.WIDTH(32), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(ir1),
    .in_a(in_a), .in_b(in_b), .abort(abort), .out_valid(ov1), .out_ready(out_ready),
    .out_gcd(og1), .out_coprime(oc1), .out_steps(os1)
  );

  gcd_engine #(.WIDTH(8), .CNT_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(ir2),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .abort(abort), .out_valid(ov2), .out_ready(out_ready),
    .out_gcd(og2), .out_coprime(oc2), .out_steps(os2)
  );

  always_comb begin
    obs_ready = ir0;
    obs_valid = ov0;
    obs_gcd   = og0;
    obs_cop   = oc0;
    obs_steps = os0;
    case (sel)
      1: begin
        obs_ready = ir1; obs_valid = ov1; obs_gcd = og1; obs_cop = oc1; obs_steps = 16'(os1);
      end
      2: begin
        obs_ready = ir2; obs_valid = ov2; obs_gcd = 32'(og2); obs_cop = oc2; obs_steps = os2;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one operand pair; returns at the first falling edge after the accept edge.
  task automatic start_job(input int d, input logic [31:0] a, input logic [31:0] b,
                           input bit push, input exp_t e);
    sel = d;
    if (push) sb.push_back(e);
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_valid_v[d] = 1'b1;
    @(negedge clk);
    in_valid_v = '0;
    check("accepted", 32'(obs_ready), 32'd0);
  endtask

  // Waits (bounded) for out_valid, pops the scoreboard and compares; completes
  // the handshake when out_ready is already high.
  task automatic finish_job(input string tag);
    int lat = 1;
    while (!obs_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_valid"}, 32'(obs_valid), 32'd1);
    check({tag, "_sb"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) last_e = sb.pop_front();
    check({tag, "_latency"}, 32'(lat), 32'(last_e.k + 1));
    check({tag, "_gcd"}, obs_gcd, last_e.gcd);
    check({tag, "_coprime"}, 32'(obs_cop), 32'(last_e.cop));
    check({tag, "_steps"}, 32'(obs_steps), 32'(last_e.steps));
    if (out_ready) begin
      @(negedge clk);
      check({tag, "_pulse"}, 32'(obs_valid), 32'd0);
      check({tag, "_ready"}, 32'(obs_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  initial begin
    int highs;
    rst_n      = 1'b0;
    in_valid_v = '0;
    in_a       = '0;
    in_b       = '0;
    abort      = 1'b0;
    out_ready  = 1'b1;
    sel        = 0;

    #23;
    check("rst_in_ready_low", 32'(ir0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(ir0), 32'd1);
    check("rst_out_valid", 32'(ov0), 32'd0);
    check("rst_gcd", og0, 32'd0);
    check("rst_coprime", 32'(oc0), 32'd0);
    check("rst_steps", 32'(os0), 32'd0);

    // Typical job
    start_job(0, 32'd48, 32'd18, 1'b1, '{32'd6, 1'b0, 16'd7, 7});
    finish_job("typ_48_18");

    // Asynchronous reset three cycles after accept; gcd register still holds 6
    start_job(0, 32'd48, 32'd18, 1'b0, '{32'd0, 1'b0, 16'd0, 0});
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_gcd", og0, 32'd0);
    check("midrst_valid", 32'(ov0), 32'd0);
    check("midrst_steps", 32'(os0), 32'd0);
    check("midrst_in_ready", 32'(ir0), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ov0) highs++;
    end
    check("midrst_no_valid", 32'(highs), 32'd0);
    check("midrst_ready_after", 32'(ir0), 32'd1);

    // Zero, equal and coprime operands
    start_job(0, 32'd0, 32'd35, 1'b1, '{32'd35, 1'b0, 16'd1, 1});
    finish_job("zero_35");
    start_job(0, 32'd0, 32'd0, 1'b1, '{32'd0, 1'b0, 16'd1, 1});
    finish_job("zero_zero");
    start_job(0, 32'd12, 32'd12, 1'b1, '{32'd12, 1'b0, 16'd1, 1});
    finish_job("eq_12");
    start_job(0, 32'd35, 32'd64, 1'b1, '{32'd1, 1'b1, 16'd14, 14});
    finish_job("cop_35_64");
    start_job(0, 32'd1, 32'h8000_0000, 1'b1, '{32'd1, 1'b1, 16'd32, 32});
    finish_job("msb_w32");

    // Backpressure: result held for 10 cycles while in_valid pulses are ignored
    out_ready = 1'b0;
    start_job(0, 32'd48, 32'd18, 1'b1, '{32'd6, 1'b0, 16'd7, 7});
    finish_job("bp");
    in_a = 32'd5;
    in_b = 32'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid_v[0] = i[0];
      check("bp_hold_valid", 32'(ov0), 32'd1);
      check("bp_hold_gcd", og0, last_e.gcd);
      check("bp_hold_steps", 32'(os0), 32'(last_e.steps));
      check("bp_hold_in_ready", 32'(ir0), 32'd0);
    end
    @(negedge clk);
    in_valid_v[0] = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid_v = '0;
    check("bp_release_valid", 32'(ov0), 32'd0);
    check("bp_no_accept_in_handshake", 32'(ir0), 32'd1);

    // Abort two cycles after accept
    start_job(0, 32'd48, 32'd18, 1'b0, '{32'd0, 1'b0, 16'd0, 0});
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_ready", 32'(ir0), 32'd1);
    check("abort_valid", 32'(ov0), 32'd0);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ov0) highs++;
    end
    check("abort_no_valid", 32'(highs), 32'd0);
    start_job(0, 32'd9, 32'd6, 1'b1, '{32'd3, 1'b0, 16'd4, 4});
    finish_job("post_abort_9_6");

    // Abort wins over out_ready in S_DONE
    out_ready = 1'b0;
    start_job(0, 32'd12, 32'd12, 1'b0, '{32'd0, 1'b0, 16'd0, 0});
    highs = 0;
    while (!ov0 && highs < 100) begin
      @(negedge clk);
      highs++;
    end
    check("done_abort_valid", 32'(ov0), 32'd1);
    abort = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("done_abort_drop", 32'(ov0), 32'd0);
    check("done_abort_ready", 32'(ir0), 32'd1);

    // Parameter variants
    start_job(1, 32'd1, 32'h8000_0000, 1'b1, '{32'd1, 1'b1, 16'd15, 32});
    finish_job("cnt4_saturate");
    start_job(2, 32'd255, 32'd255, 1'b1, '{32'd255, 1'b0, 16'd1, 1});
    finish_job("w8_255");

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_engine.md
# gcd_engine

Parametrised binary (Stein) GCD engine with valid/ready handshakes on both sides, zero-operand handling, an abort input, a coprime flag and a per-job step counter. It succeeds the fixed 32-bit start/done GCD core and sits behind a stream or DMA front-end. The output side supports backpressure, so the front-end can stall results without losing them.

## Interface
- `WIDTH`, default 32: operand and result width, ≥ 2.
- `CNT_W`, default 16: step-counter width, ≥ 1.
- `N_W`, derived as `$clog2(WIDTH)`, min 1: width of the shared-power-of-two counter `n`.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: operand pair valid.
- `in_ready`, out, 1: engine idle and able to accept.
- `in_a`, in, WIDTH: operand A.
- `in_b`, in, WIDTH: operand B.
- `abort`, in, 1: drop the current job.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts the result.
- `out_gcd`, out, WIDTH: gcd(A, B).
- `out_coprime`, out, 1: 1 iff `out_gcd == 1`.
- `out_steps`, out, CNT_W: number of S_OP cycles spent on the job, saturating.

## Operation
- States:
  - S_IDLE: `in_ready = 1`.
  - S_OP: one reduction step per cycle.
  - S_DONE: `out_valid = 1`; all `out_*` held stable.
- **Accept** (S_IDLE, `in_valid` = 1):
  - Load `a_reg = in_a`, `b_reg = in_b`, `n = 0`, `steps = 0`.
  - Next state S_OP.
  - `abort` is ignored in S_IDLE.
- **S_OP step.** Every S_OP cycle increments `steps`; it saturates at `2^CNT_W - 1`. Rules are evaluated in priority order:
  1. `a_reg == 0` or `b_reg == 0`: result = `(a_reg | b_reg) << n`; go to S_DONE. gcd(0, 0) = 0 and coprime = 0.
  2. `a_reg == b_reg`: result = `a_reg << n`; go to S_DONE.
  3. Both even: `a_reg >>= 1`, `b_reg >>= 1`, `n += 1`.
  4. `a_reg` even only: `a_reg >>= 1`.
  5. `b_reg` even only: `b_reg >>= 1`.
  6. Both odd: the larger operand is replaced by `larger − smaller`.
- Arithmetic and width rules:
  - All shifts are logical.
  - The final shift is a single-cycle barrel shift, truncated to WIDTH. It never overflows, because both inputs are divisible by `2^n`.
  - `n` never exceeds WIDTH−1.
- **Result registers.** `out_gcd`, `out_coprime` and `out_steps` are registered on the terminating S_OP cycle.
- **S_DONE → S_IDLE** on `out_valid && out_ready`.
  - No new job is accepted in the handshake cycle.
  - `in_ready` rises the following cycle.
- **Abort:**
  - In S_OP or S_DONE, `abort = 1` forces S_IDLE on the next edge. No result is produced and `out_valid` falls.
  - If `abort` and `out_ready` are both high in S_DONE, `abort` wins: the transaction is counted as dropped. Consumers must not take data when `abort` is asserted.
- **Reset** (asynchronous, any state, including mid-job):
  - State returns to S_IDLE.
  - `out_valid = 0`, `out_gcd = 0`, `out_coprime = 0`, `out_steps = 0`.
  - Internal `a_reg`, `b_reg`, `n` and `steps` are cleared to 0.
  - `in_ready = 1` immediately after reset deassertion.

## Timing
- `in_ready` and `out_valid` are decoded combinationally from the state register only. There is no combinational path from `in_valid` or `out_ready` to them.
- Latency: accept at edge T. S_OP cycles occupy T+1 … T+k. `out_valid` is high from T+k+1, and `out_steps = k`.
- Minimum k = 1 (equal operands or a zero operand). Worst case k ≤ 2·WIDTH + 1.
- Throughput: one job per k + 2 cycles when `out_ready` is tied high.
- Result data is stable for the whole time `out_valid` is high, however long `out_ready` stays low.

## Test plan
1. **Reset:** `rst_n` low mid-S_OP (a=48, b=18, 3 cycles after accept) → outputs go to 0 asynchronously; `in_ready = 1` after release; no `out_valid`.
2. **Typical job:** a=48, b=18, `out_ready = 1` → `out_gcd = 6`, `out_coprime = 0`, `out_steps = 7`; `out_valid` high exactly 8 cycles after the accept edge, for exactly 1 cycle.
3. **Zero and equal operands:**
   - (0, 35) → gcd 35, steps 1.
   - (0, 0) → gcd 0, coprime 0.
   - (12, 12) → gcd 12, steps 1.
   - (35, 64) → gcd 1, coprime 1.
4. **Backpressure:** (48, 18) with `out_ready` low for 10 cycles after `out_valid` → `out_valid` and data held constant; `in_ready` stays 0; `in_valid` pulses are ignored; job completes once `out_ready` = 1.
5. **Abort:**
   - (48, 18) with `abort` pulsed 2 cycles after accept → S_IDLE next cycle; no `out_valid`.
   - Next job (9, 6) → gcd 3, `out_steps` counted from 0.
6. **Parameters:** `WIDTH = 32`, `CNT_W = 4`, job (1, 0x80000000) → gcd 1, coprime 1, `out_steps` saturates at 15. `WIDTH = 8`, (255, 255) → gcd 255.
